// File: rtl/urv_writeback_pkg.sv
// uRV writeback stage: shared width codes, result-source selects
// and writeback FSM state encoding.
package urv_writeback_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'b00;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'b01;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'b10;

    localparam int WB_CNT_W = 8;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/urv_writeback_if.sv
// Data-memory completion and register-file write port bundle
// between the writeback stage and its neighbours.
interface urv_writeback_if;

    logic [31:0] dm_data_l;
    logic        dm_load_done;
    logic        dm_store_done;

    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_value;
    logic        rf_rd_write;
    logic [1:0]  rf_ecc_flip;

    modport master (
        input  dm_data_l, dm_load_done, dm_store_done,
        output rf_rd, rf_rd_value, rf_rd_write, rf_ecc_flip
    );

    modport slave (
        output dm_data_l, dm_load_done, dm_store_done,
        input  rf_rd, rf_rd_value, rf_rd_write, rf_ecc_flip
    );

endinterface

// File: rtl/urv_writeback_load_align.sv
// Load data lane extraction with sign/zero extension.
// Word loads pass through; alignment is trapped upstream.
module urv_load_align
    import urv_writeback_pkg::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  lane,
    input  logic [31:0] data,
    output logic [31:0] aligned
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (lane)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lane[1] ? data[31:16] : data[15:0];

        unique case (fun)
            LDST_B:  aligned = {{24{b[7]}}, b};
            LDST_BU: aligned = {24'h0, b};
            LDST_H:  aligned = {{16{h[15]}}, h};
            LDST_HU: aligned = {16'h0, h};
            default: aligned = data;
        endcase
    end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: result select, load completion wait with
// timeout, register-file write port and one-entry bypass register.
module urv_writeback
    import urv_writeback_pkg::*;
#(
    parameter int g_with_hw_mul = 0,
    parameter int g_mem_timeout = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        w_stall_i,
    output logic        w_stall_req_o,
    input  logic        x_valid_i,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_rd_shifter_i,
    input  logic [31:0] x_rd_multiply_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [1:0]  x_ecc_flip_i,
    urv_writeback_if.master wb,
    output logic        byp_valid_o,
    output logic [4:0]  byp_rd_o,
    output logic [31:0] byp_value_o,
    output logic        w_bus_err_o
);

    localparam logic [WB_CNT_W-1:0] TMO = WB_CNT_W'(g_mem_timeout);

    wb_state_t           state, state_nxt;
    logic [WB_CNT_W-1:0] cnt, cnt_nxt;
    logic                is_mem, mem_done;
    logic                retire, stall_req, bus_err;
    logic                rf_write;
    logic [31:0]         load_value, src_value;
    logic                unused_addr;

    assign unused_addr = ^x_dm_addr_i[31:2];

    urv_load_align u_align (
        .fun     (x_fun_i),
        .lane    (x_dm_addr_i[1:0]),
        .data    (wb.dm_data_l),
        .aligned (load_value)
    );

    assign is_mem   = x_load_i | x_store_i;
    assign mem_done = (x_load_i & wb.dm_load_done)
                    | (x_store_i & wb.dm_store_done);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retire    = 1'b0;
        stall_req = 1'b0;
        bus_err   = 1'b0;
        unique case (state)
            WB_S_IDLE: begin
                if (x_valid_i) begin
                    if (!is_mem || mem_done) begin
                        retire = 1'b1;
                    end else begin
                        stall_req = 1'b1;
                        state_nxt = WB_S_WAIT;
                        cnt_nxt   = WB_CNT_W'(1);
                    end
                end
            end
            WB_S_WAIT: begin
                // a done in the timeout cycle takes priority
                if (mem_done) begin
                    retire = 1'b1;
                end else if (TMO != '0 && cnt == TMO) begin
                    bus_err = 1'b1;
                end else begin
                    stall_req = 1'b1;
                    cnt_nxt   = cnt + WB_CNT_W'(1);
                end
            end
            WB_S_DONE: begin
                cnt_nxt = '0;
                if (!w_stall_i) state_nxt = WB_S_IDLE;
            end
            default: state_nxt = WB_S_IDLE;
        endcase
        if (retire || bus_err) begin
            cnt_nxt   = '0;
            state_nxt = w_stall_i ? WB_S_DONE : WB_S_IDLE;
        end
        if (!rst_n_i) begin
            retire    = 1'b0;
            stall_req = 1'b0;
            bus_err   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= WB_S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        unique case (x_rd_source_i)
            RD_SOURCE_SHIFTER:  src_value = x_rd_shifter_i;
            RD_SOURCE_MULTIPLY: src_value = (g_with_hw_mul != 0)
                                          ? x_rd_multiply_i : 32'h0;
            default:            src_value = x_rd_value_i;
        endcase
    end

    assign rf_write = retire & x_rd_write_i & (x_rd_i != 5'd0);

    assign wb.rf_rd_write = rf_write;
    assign wb.rf_rd       = rf_write ? x_rd_i : 5'd0;
    assign wb.rf_rd_value = !rf_write ? 32'h0
                          : (x_load_i ? load_value : src_value);
    assign wb.rf_ecc_flip = rf_write ? x_ecc_flip_i : 2'b00;

    assign w_stall_req_o = stall_req;
    assign w_bus_err_o   = bus_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byp_valid_o <= 1'b0;
            byp_rd_o    <= 5'd0;
            byp_value_o <= 32'h0;
        end else begin
            byp_valid_o <= rf_write;
            if (rf_write) begin
                byp_rd_o    <= wb.rf_rd;
                byp_value_o <= wb.rf_rd_value;
            end
        end
    end

endmodule

// File: tb/tb_urv_writeback.sv
// Scoreboard bench for urv_writeback: random ops against a
// behavioural model, checked by an independent monitor.
module tb_urv_writeback;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        w_stall_i;
    logic        w_stall_req_o;
    logic        x_valid_i;
    logic [2:0]  x_fun_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [31:0] x_rd_value_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_rd_shifter_i;
    logic [31:0] x_rd_multiply_i;
    logic [31:0] x_dm_addr_i;
    logic [1:0]  x_ecc_flip_i;
    logic        byp_valid_o;
    logic [4:0]  byp_rd_o;
    logic [31:0] byp_value_o;
    logic        w_bus_err_o;

    urv_writeback_if wif ();

    urv_writeback #(
        .g_with_hw_mul (1),
        .g_mem_timeout (TMO)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .w_stall_i       (w_stall_i),
        .w_stall_req_o   (w_stall_req_o),
        .x_valid_i       (x_valid_i),
        .x_fun_i         (x_fun_i),
        .x_load_i        (x_load_i),
        .x_store_i       (x_store_i),
        .x_rd_i          (x_rd_i),
        .x_rd_write_i    (x_rd_write_i),
        .x_rd_value_i    (x_rd_value_i),
        .x_rd_source_i   (x_rd_source_i),
        .x_rd_shifter_i  (x_rd_shifter_i),
        .x_rd_multiply_i (x_rd_multiply_i),
        .x_dm_addr_i     (x_dm_addr_i),
        .x_ecc_flip_i    (x_ecc_flip_i),
        .wb              (wif),
        .byp_valid_o     (byp_valid_o),
        .byp_rd_o        (byp_rd_o),
        .byp_value_o     (byp_value_o),
        .w_bus_err_o     (w_bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          err;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [1:0]  flip;
    } ev_t;

    ev_t sb[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference load extraction by plain shifts and modular arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] fun,
                                             input logic [1:0] lane,
                                             input logic [31:0] d);
        int unsigned b, h;
        b = (d >> (8 * lane)) % 256;
        h = (d >> (16 * (lane / 2))) % 65536;
        case (fun)
            3'b000:  return 32'(b) - ((b >= 128) ? 32'd256 : 32'd0);
            3'b100:  return 32'(b);
            3'b001:  return 32'(h) - ((h >= 32768) ? 32'd65536 : 32'd0);
            3'b101:  return 32'(h);
            default: return d;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever the DUT writes or errors
    bit          prev_wr = 0;
    logic [4:0]  prev_rd;
    logic [31:0] prev_val;
    ev_t         mon_e;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            chk("rst_rf_write", 32'(wif.rf_rd_write), 0);
            chk("rst_byp_valid", 32'(byp_valid_o), 0);
            chk("rst_bus_err", 32'(w_bus_err_o), 0);
            prev_wr = 0;
        end else begin
            chk("byp_valid", 32'(byp_valid_o), 32'(prev_wr));
            if (prev_wr) begin
                chk("byp_rd", 32'(byp_rd_o), 32'(prev_rd));
                chk("byp_value", byp_value_o, prev_val);
            end
            if (wif.rf_rd_write || w_bus_err_o) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_event: write=%b err=%b rd=%0d",
                             wif.rf_rd_write, w_bus_err_o, wif.rf_rd);
                    prev_wr = 0;
                end else begin
                    mon_e = sb.pop_front();
                    chk("bus_err", 32'(w_bus_err_o), 32'(mon_e.err));
                    chk("rf_write", 32'(wif.rf_rd_write), 32'(!mon_e.err));
                    if (!mon_e.err) begin
                        chk("rf_rd", 32'(wif.rf_rd), 32'(mon_e.rd));
                        chk("rf_value", wif.rf_rd_value, mon_e.val);
                        chk("rf_flip", 32'(wif.rf_ecc_flip), 32'(mon_e.flip));
                    end
                    prev_wr  = !mon_e.err;
                    prev_rd  = mon_e.rd;
                    prev_val = mon_e.val;
                end
            end else begin
                prev_wr = 0;
                chk("idle_flip", 32'(wif.rf_ecc_flip), 0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            x_valid_i = 1'b0;
            w_stall_i = 1'b0;
            x_rd_i = 5'($urandom);
            x_rd_write_i = 1'b1;
            wif.dm_load_done = 1'b0;
            wif.dm_store_done = 1'b0;
            wif.dm_data_l = $urandom;
            @(posedge clk_i); #1;
        end
    endtask

    // One instruction; wait_n > TMO means the memory never answers
    task automatic do_op(input bit ld, input bit st, input logic [2:0] fun,
                         input logic [4:0] rd, input bit wr,
                         input logic [1:0] src, input logic [31:0] val,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] flip, input int wait_n,
                         input int hold);
        bit          mem, tmo;
        int          ncyc;
        logic [31:0] sh, mul, ev;
        ev_t         e;
        mem  = ld || st;
        tmo  = mem && (wait_n > TMO);
        ncyc = !mem ? 0 : (tmo ? TMO : wait_n);
        sh   = $urandom;
        mul  = $urandom;
        if (ld) ev = ref_load(fun, addr[1:0], data);
        else if (src == 2'b01) ev = sh;
        else if (src == 2'b10) ev = mul;
        else ev = val;
        e.err = tmo; e.rd = rd; e.val = ev; e.flip = flip;
        if (tmo || (wr && rd != 5'd0)) sb.push_back(e);

        x_valid_i = 1'b1; x_load_i = ld; x_store_i = st;
        x_fun_i = fun; x_rd_i = rd; x_rd_write_i = wr;
        x_rd_source_i = src; x_rd_value_i = val;
        x_rd_shifter_i = sh; x_rd_multiply_i = mul;
        x_dm_addr_i = addr; x_ecc_flip_i = flip;
        for (int c = 0; c <= ncyc; c++) begin
            w_stall_i = (c == ncyc) && (hold > 0);
            wif.dm_load_done = ld && (c == wait_n);
            wif.dm_store_done = st && (c == wait_n);
            wif.dm_data_l = (c == wait_n) ? data : $urandom;
            #1;
            chk("stall_req", 32'(w_stall_req_o), 32'(c < ncyc));
            @(posedge clk_i); #1;
        end
        for (int h = 0; h < hold; h++) begin
            w_stall_i = (h < hold - 1);
            wif.dm_load_done = ld;
            wif.dm_store_done = st;
            wif.dm_data_l = $urandom;
            #1;
            chk("held_stall_req", 32'(w_stall_req_o), 0);
            @(posedge clk_i); #1;
        end
        wif.dm_load_done = 1'b0;
        wif.dm_store_done = 1'b0;
        w_stall_i = 1'b0;
    endtask

    initial begin
        logic [2:0] lfun [5];
        lfun = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n_i = 1'b0; w_stall_i = 1'b0; x_valid_i = 1'b0;
        x_load_i = 1'b0; x_store_i = 1'b0; x_fun_i = 3'b0;
        x_rd_i = 5'd0; x_rd_write_i = 1'b0; x_rd_source_i = 2'b0;
        x_rd_value_i = 0; x_rd_shifter_i = 0; x_rd_multiply_i = 0;
        x_dm_addr_i = 0; x_ecc_flip_i = 2'b0;
        wif.dm_data_l = 0; wif.dm_load_done = 1'b0;
        wif.dm_store_done = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_stall_req", 32'(w_stall_req_o), 0);
        chk("reset_byp_rd", 32'(byp_rd_o), 0);
        chk("reset_byp_value", byp_value_o, 0);
        chk("reset_rf_value", wif.rf_rd_value, 0);
        rst_n_i = 1'b1;
        idle(2);

        do_op(0, 0, 3'b0, 5'd5, 1, 2'b00, 32'h1234, 0, 0, 2'b01, 0, 0);
        idle(1);
        do_op(1, 0, 3'b000, 5'd6, 1, 2'b00, 0, 32'h3, 32'h80FF_0000, 0, 0, 0);
        do_op(1, 0, 3'b100, 5'd6, 1, 2'b00, 0, 32'h3, 32'h80FF_0000, 0, 0, 0);
        do_op(1, 0, 3'b001, 5'd7, 1, 2'b00, 0, 32'h2, 32'h8001_1234, 0, 3, 0);
        do_op(0, 1, 3'b010, 5'd0, 0, 2'b00, 0, 32'h0, 0, 0, 99, 0);
        idle(1);
        do_op(1, 0, 3'b010, 5'd9, 1, 2'b00, 0, 32'h0, 32'hCAFE_F00D, 2'b10, 1, 3);
        do_op(0, 0, 3'b0, 5'd0, 1, 2'b00, 32'hDEAD, 0, 0, 2'b11, 0, 0);
        idle(2);

        // abandon a wait with an asynchronous reset
        x_valid_i = 1'b1; x_load_i = 1'b1; x_store_i = 1'b0;
        x_rd_i = 5'd10; x_rd_write_i = 1'b1; x_fun_i = 3'b010;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("rst_wait_stall_req", 32'(w_stall_req_o), 0);
        chk("rst_wait_rf_write", 32'(wif.rf_rd_write), 0);
        chk("rst_wait_bus_err", 32'(w_bus_err_o), 0);
        chk("rst_wait_byp_valid", 32'(byp_valid_o), 0);
        chk("rst_wait_byp_rd", 32'(byp_rd_o), 0);
        x_valid_i = 1'b0; x_load_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(1);

        for (int i = 0; i < 300; i++) begin
            int  kind, wn, hd;
            bit  ld, st;
            kind = $urandom_range(0, 2);
            ld = (kind == 1);
            st = (kind == 2);
            wn = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 6);
            hd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_op(ld, st,
                  ld ? lfun[$urandom_range(0, 4)] : 3'($urandom),
                  5'($urandom), !st && ($urandom_range(0, 7) != 0),
                  2'($urandom), $urandom, $urandom, $urandom,
                  2'($urandom), wn, hd);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        total_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0",
                      sb.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
